// File: rtl/npc_unit.sv
// npc_unit: next-PC generator for the MIPS fetch stage.
// Owns the fetch PC register and selects the next PC from the sequential,
// branch, jump, register-jump, return and ERET paths. Exceptions override
// everything. A small return-address stack tracks JAL history and checks
// each jr $ra target against it. The check is advisory only: the stack
// never redirects fetch.
module npc_unit #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR = 32'h0000_4180,
    parameter int                 RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic             take,
    input  logic [WIDTH-1:0] pc4,
    input  logic [25:0]      imm,
    input  logic [WIDTH-1:0] target_reg,
    input  logic [WIDTH-1:0] epc,
    input  logic             exc_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] npc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_mismatch,
    output logic             ras_overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_JAL  = 3'd3;
    localparam logic [2:0] OP_JR   = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_ERET = 3'd6;

    localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Branch target: base plus the sign-extended word offset, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] br_target(input logic [WIDTH-1:0] base,
                                                   input logic [15:0]      off);
        logic signed [WIDTH-1:0] soff;
        soff = {{(WIDTH-16){off[15]}}, off};
        soff = soff <<< 2;
        return base + $unsigned(soff);
    endfunction

    // Jump target: keep the upper region bits of the delay-slot PC.
    function automatic logic [WIDTH-1:0] j_target(input logic [WIDTH-1:0] base,
                                                  input logic [25:0]      index);
        return {base[WIDTH-1:28], index, 2'b00};
    endfunction

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;      // next free slot; top entry sits just below
    logic [CNT_W-1:0] ras_cnt;
    logic [WIDTH-1:0] ras_top;
    logic             ras_upd;
    logic             ras_push;
    logic             ras_pop;

    assign pc_seq    = pc + FOUR;
    assign ras_top   = ras_mem[ras_ptr - PTR_ONE];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_FULL);

    // The stack only moves on cycles that actually retire a control transfer.
    assign ras_upd   = !stall && !exc_req;
    assign ras_push  = ras_upd && (op == OP_JAL);
    assign ras_pop   = ras_upd && (op == OP_RET);

    // Next-PC select; exception has the highest priority, reserved op acts as SEQ.
    always_comb begin
        npc = pc_seq;
        if (exc_req) begin
            npc = EXC_VECTOR;
        end else begin
            case (op)
                OP_SEQ:         npc = pc_seq;
                OP_BR:          npc = take ? br_target(pc4, imm[15:0]) : pc_seq;
                OP_J, OP_JAL:   npc = j_target(pc4, imm);
                OP_JR, OP_RET:  npc = target_reg;
                OP_ERET:        npc = epc;
                default:        npc = pc_seq;
            endcase
        end
    end

    // Fetch PC register: exception redirect wins even over a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (exc_req) begin
            pc <= EXC_VECTOR;
        end else if (!stall) begin
            pc <= npc;
        end
    end

    // Stack storage: data only, no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_ptr] <= pc4 + FOUR;
        end
    end

    // Stack control: pointer, occupancy, mismatch pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_ptr      <= '0;
            ras_cnt      <= '0;
            ras_mismatch <= 1'b0;
            ras_overflow <= 1'b0;
        end else begin
            ras_mismatch <= 1'b0;
            if (ras_push) begin
                // When full, the next free slot is the oldest entry, so the
                // write overwrites it and the occupancy stays saturated.
                ras_ptr <= ras_ptr + PTR_ONE;
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CNT_ONE;
                end
            end else if (ras_pop) begin
                if (ras_empty) begin
                    ras_mismatch <= 1'b1;
                end else begin
                    ras_mismatch <= (ras_top != target_reg);
                    ras_ptr      <= ras_ptr - PTR_ONE;
                    ras_cnt      <= ras_cnt - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_npc_unit.sv
// Testbench for npc_unit: a reference model predicts npc and post-edge state,
// expectations are queued at drive time and popped when the DUT responds.
module tb_npc_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  op;
    logic        take;
    logic [31:0] pc4;
    logic [25:0] imm;
    logic [31:0] target_reg;
    logic [31:0] epc;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_mismatch;
    logic        ras_overflow;

    npc_unit #(
        .WIDTH(32),
        .RESET_PC(32'h0000_3000),
        .EXC_VECTOR(32'h0000_4180),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .op(op),
        .take(take),
        .pc4(pc4),
        .imm(imm),
        .target_reg(target_reg),
        .epc(epc),
        .exc_req(exc_req),
        .pc(pc),
        .npc(npc),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_mismatch(ras_mismatch),
        .ras_overflow(ras_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        mism;
        logic        ovf;
    } exp_t;

    exp_t        st_q[$];
    logic [31:0] npc_q[$];

    // Reference model state: the stack is a plain queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_mism;
    logic        m_ovf;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic [2:0] o, input logic t,
                                              input logic [31:0] p4, input logic [25:0] im,
                                              input logic [31:0] tr, input logic [31:0] ep,
                                              input logic e);
        logic [31:0] off;
        if (e) return 32'h0000_4180;
        off = {{14{im[15]}}, im[15:0], 2'b00};
        case (o)
            3'd1:       return t ? p4 + off : m_pc + 32'd4;
            3'd2, 3'd3: return {p4[31:28], im, 2'b00};
            3'd4, 3'd5: return tr;
            3'd6:       return ep;
            default:    return m_pc + 32'd4;
        endcase
    endfunction

    // One clock of stimulus: drive, queue expectations, check npc, then state.
    task automatic step(input logic r, input logic s, input logic [2:0] o, input logic t,
                        input logic [31:0] p4, input logic [25:0] im, input logic [31:0] tr,
                        input logic [31:0] ep, input logic e);
        logic [31:0] en;
        exp_t        ex;
        exp_t        got;
        @(negedge clk);
        rst_n = r; stall = s; op = o; take = t; pc4 = p4; imm = im;
        target_reg = tr; epc = ep; exc_req = e;
        en = model_npc(o, t, p4, im, tr, ep, e);
        if (r) npc_q.push_back(en);
        if (!r) begin
            m_pc = 32'h0000_3000;
            m_ras.delete();
            m_mism = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_mism = 1'b0;
            if (!s && !e) begin
                if (o == 3'd3) begin
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(p4 + 32'd4);
                end else if (o == 3'd5) begin
                    if (m_ras.size() == 0) m_mism = 1'b1;
                    else m_mism = (m_ras.pop_back() != tr);
                end
            end
            if (e) m_pc = 32'h0000_4180;
            else if (!s) m_pc = en;
        end
        ex.pc = m_pc;
        ex.empty = (m_ras.size() == 0);
        ex.full = (m_ras.size() == DEPTH);
        ex.mism = m_mism;
        ex.ovf = m_ovf;
        st_q.push_back(ex);
        #1;
        if (r) check("npc", npc, npc_q.pop_front());
        @(posedge clk);
        #1;
        got = st_q.pop_front();
        check("pc", pc, got.pc);
        check("ras_empty", {31'd0, ras_empty}, {31'd0, got.empty});
        check("ras_full", {31'd0, ras_full}, {31'd0, got.full});
        check("ras_mismatch", {31'd0, ras_mismatch}, {31'd0, got.mism});
        check("ras_overflow", {31'd0, ras_overflow}, {31'd0, got.ovf});
    endtask

    // Short forms for the common cases.
    task automatic go(input logic [2:0] o, input logic t, input logic [31:0] p4,
                      input logic [25:0] im, input logic [31:0] tr);
        step(1'b1, 1'b0, o, t, p4, im, tr, 32'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r_tr;
        logic [31:0] r_p4;
        logic [25:0] r_im;
        logic [2:0]  r_op;
        m_pc = 32'h0; m_mism = 1'b0; m_ovf = 1'b0;
        rst_n = 1'b0; stall = 1'b0; op = 3'd0; take = 1'b0; pc4 = '0; imm = '0;
        target_reg = '0; epc = '0; exc_req = 1'b0;

        // Reset held two cycles with a jump on op.
        step(1'b0, 1'b0, 3'd2, 1'b0, 32'h3004, 26'h0000C10, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 3'd2, 1'b0, 32'h3004, 26'h0000C10, 32'd0, 32'd0, 1'b0);
        check("rst_pc_lit", pc, 32'h0000_3000);
        check("rst_empty_lit", {31'd0, ras_empty}, 32'd1);
        go(3'd0, 1'b0, 32'd0, 26'd0, 32'd0);
        check("seq_pc_lit", pc, 32'h0000_3004);

        // Backward taken branch, then not-taken from pc=0x3014.
        go(3'd1, 1'b1, 32'h3010, 26'h000FFFC, 32'd0);
        check("br_taken_lit", pc, 32'h0000_3000);
        go(3'd2, 1'b0, 32'h3000, 26'h0000C05, 32'd0);
        go(3'd1, 1'b0, 32'h3010, 26'h000FFFC, 32'd0);
        check("br_not_taken_lit", pc, 32'h0000_3018);

        // JAL / matching RET / mismatching RET and its one-cycle pulse.
        go(3'd3, 1'b0, 32'h3004, 26'h0000C10, 32'd0);
        check("jal_pc_lit", pc, 32'h0000_3040);
        go(3'd5, 1'b0, 32'h3044, 26'd0, 32'h3008);
        go(3'd3, 1'b0, 32'h3004, 26'h0000C10, 32'd0);
        go(3'd5, 1'b0, 32'h3044, 26'd0, 32'h300C);
        check("ret_mism_lit", {31'd0, ras_mismatch}, 32'd1);
        go(3'd7, 1'b0, 32'd0, 26'd0, 32'd0);

        // Overflow: DEPTH+1 JALs, DEPTH LIFO RETs, one RET on empty.
        for (int i = 0; i <= DEPTH; i++) go(3'd3, 1'b0, 32'h3000 + 32'(16 * i), 26'h0000C00, 32'd0);
        check("ovf_lit", {31'd0, ras_overflow}, 32'd1);
        for (int i = DEPTH; i >= 1; i--) go(3'd5, 1'b0, 32'h3000, 26'd0, 32'h3004 + 32'(16 * i));
        go(3'd5, 1'b0, 32'h3000, 26'd0, 32'h3004);
        go(3'd0, 1'b0, 32'd0, 26'd0, 32'd0);

        // Mid-run reset clears the sticky overflow.
        step(1'b0, 1'b1, 3'd3, 1'b1, 32'h3100, 26'd0, 32'd0, 32'd0, 1'b1);

        // Stall with JAL, then exception during stall, then ERET.
        go(3'd3, 1'b0, 32'h3100, 26'h0000C00, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd3, 1'b0, 32'h3200, 26'h0000D00, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 3'd3, 1'b0, 32'h3200, 26'h0000D00, 32'd0, 32'd0, 1'b1);
        check("exc_pc_lit", pc, 32'h0000_4180);
        step(1'b1, 1'b0, 3'd6, 1'b0, 32'd0, 26'd0, 32'd0, 32'h3020, 1'b0);
        check("eret_pc_lit", pc, 32'h0000_3020);
        go(3'd5, 1'b0, 32'h3000, 26'd0, 32'h3104);

        // Wrap-around of the sequential path and a branch below zero.
        go(3'd4, 1'b0, 32'd0, 26'd0, 32'hFFFF_FFFC);
        go(3'd0, 1'b0, 32'd0, 26'd0, 32'd0);
        check("wrap_lit", pc, 32'h0000_0000);
        go(3'd1, 1'b1, 32'h0000_0004, 26'h000FFFE, 32'd0);
        check("br_wrap_lit", pc, 32'hFFFF_FFFC);

        // Mixed random traffic.
        for (int i = 0; i < 80; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_p4 = 32'h3000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            r_im = 26'($urandom);
            r_tr = {$urandom, 2'b00};
            if (r_op == 3'd5 && m_ras.size() > 0 && $urandom_range(0, 1) == 1) r_tr = m_ras[$];
            step(1'b1, ($urandom_range(0, 3) == 0), r_op, 1'($urandom),
                 r_p4, r_im, r_tr, {$urandom, 2'b00}, ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Parametrised next-PC generator for the MIPS pipeline: owns the fetch PC register and selects among sequential, branch, J/JAL, JR, return and ERET targets.
- Also selects the exception vector.
- Adds stall hold, exception override, and a return-address stack (RAS) that checks JR $ra targets against JAL history.
- Sits between the decode/branch-compare logic and the instruction memory address port.

Parameters:
- WIDTH, 32, address width (must be ≥ 30).
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.
- RAS_DEPTH, 4, RAS entries (power of two, ≥ 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold PC; suppress RAS update
- op  in  3  0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 RET (jr $ra), 6 ERET, 7 reserved (= SEQ)
- take  in  1  branch condition for BR
- pc4  in  WIDTH  PC+4 of the instruction in decode
- imm  in  26  instr_index[25:0]; BR uses imm[15:0]
- target_reg  in  WIDTH  GPR[rs] for JR/RET
- epc  in  WIDTH  return address for ERET
- exc_req  in  1  exception redirect request
- pc  out  WIDTH  current fetch PC (registered)
- npc  out  WIDTH  selected next PC (combinational)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- ras_mismatch  out  1  registered one-cycle pulse
- ras_overflow  out  1  sticky; cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge): pc=RESET_PC, RAS count=0, top pointer=0, ras_mismatch=0, ras_overflow=0. Reset overrides every other input in that cycle.
- npc selection, in priority order:
  - exc_req → EXC_VECTOR.
  - op:
    - SEQ: pc+4.
    - BR: take ? pc4 + (sext(imm[15:0])<<2) : pc+4.
    - J/JAL: {pc4[WIDTH-1:28], imm, 2'b00}.
    - JR/RET: target_reg.
    - ERET: epc.
  - All additions are modulo 2^WIDTH; no overflow detection.
- PC update at clk edge:
  - exc_req=1 → pc<=EXC_VECTOR, even when stall=1.
  - Else stall=0 → pc<=npc.
  - Else pc holds.
- RAS updates only when stall=0 and exc_req=0.
  - JAL push: value pc4+4 (return address past the delay slot).
    - Not full: store at top, count+1.
    - Full: circular overwrite of the oldest entry, count stays RAS_DEPTH, ras_overflow<=1.
  - RET pop:
    - Non-empty: ras_mismatch<=(top != target_reg), count-1.
    - Empty: no state change, ras_mismatch<=1.
  - All other ops, stalled cycles, and exception cycles leave the RAS unchanged and set ras_mismatch<=0.
- ras_mismatch is advisory only. The RET target is always target_reg; the RAS never redirects the PC.
- Latency: npc is valid in the same cycle as its inputs; pc reflects it one edge later.
- Exception mid-stall: the redirect wins, and the stalled instruction is the responsibility of the pipeline flush logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with op=J → pc=0x3000, ras_empty=1, ras_overflow=0; first release cycle with op=SEQ → pc=0x3004.
- Branch taken, backward offset: pc4=0x3010, imm[15:0]=0xFFFC, take=1 → npc=0x3000. Same inputs with take=0 and pc=0x3014 → npc=0x3018.
- J/JAL/RET: pc4=0x3004, JAL with imm=0x0000C10 → npc=0x3040, RAS top=0x3008. Then RET with target_reg=0x3008 → npc=0x3008, ras_mismatch=0, ras_empty=1. A RET with target_reg=0x300C instead → ras_mismatch=1 for exactly one cycle.
- Overflow: RAS_DEPTH+1 consecutive JALs with pc4=0x3000, 0x3010, … → ras_full=1, ras_overflow=1. Then RAS_DEPTH RETs return the newest RAS_DEPTH values in LIFO order; one more RET → ras_mismatch=1, count stays 0.
- Stall plus exception: stall=1 with op=JAL for 3 cycles → pc constant, RAS unchanged. Assert exc_req during the stall → next pc=0x4180. A following ERET with epc=0x3020 → pc=0x3020.
- Wrap-around: pc=0xFFFF_FFFC with op=SEQ → pc=0x0000_0000. BR with pc4=0x0000_0004, imm=0xFFFE, take=1 → npc=0xFFFF_FFFC.
